// File: rtl/vga_plot_sink_pkg.sv
// Shared definitions for the plot sink: default geometry, colour type,
// frame-buffer address width and the (x, y) -> linear address mapping.
package vga_plot_sink_pkg;

    localparam int WIDTH_DEF  = 160;
    localparam int HEIGHT_DEF = 120;
    localparam int ADDR_W     = 15;

    typedef logic [2:0] colour_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    // Row-major address; the product is formed at full width and then trimmed.
    function automatic logic [ADDR_W-1:0] xy_to_addr(input logic [7:0] x,
                                                     input logic [7:0] y,
                                                     input int width);
        int lin;
        lin = int'({24'd0, y}) * width + int'({24'd0, x});
        return lin[ADDR_W-1:0];
    endfunction

endpackage

// File: rtl/vga_plot_sink_if.sv
// Pixel-plot and raster-out bundle between the drawing FSMs (master)
// and the frame-buffer sink (slave).
interface vga_plot_sink_if;
    import vga_plot_sink_pkg::*;

    logic [7:0] iX;
    logic [6:0] iY;
    colour_t    iColour;
    logic       iPlot;
    logic       iClear;
    logic       iPixEn;

    logic       oBusy;
    logic [7:0] oDropped;
    logic [7:0] oRasterX;
    logic [6:0] oRasterY;
    colour_t    oPixColour;
    logic       oActive;
    logic       oHSync;
    logic       oVSync;
    logic       oFrameStart;

    modport master (
        output iX, iY, iColour, iPlot, iClear, iPixEn,
        input  oBusy, oDropped, oRasterX, oRasterY, oPixColour,
               oActive, oHSync, oVSync, oFrameStart
    );

    modport slave (
        input  iX, iY, iColour, iPlot, iClear, iPixEn,
        output oBusy, oDropped, oRasterX, oRasterY, oPixColour,
               oActive, oHSync, oVSync, oFrameStart
    );

endinterface

// File: rtl/vga_plot_sink_fb_ram.sv
// Frame buffer: one write port, one registered read port. A write and a read
// of the same address on one edge return the old contents (read-first).
module vga_plot_sink_fb_ram
    import vga_plot_sink_pkg::*;
#(
    parameter int DEPTH = WIDTH_DEF * HEIGHT_DEF
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  colour_t           wr_data,
    input  logic              re,
    input  logic [ADDR_W-1:0] rd_addr,
    output colour_t           rd_data
);

    colour_t mem [DEPTH];

    // Write port: contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) mem[wr_addr] <= wr_data;
    end

    // Read port: registered, only advances on a pixel tick.
    always_ff @(posedge clk) begin
        if (re) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/vga_plot_sink.sv
// Plot sink: accepts one pixel write per clock, runs a full-buffer clear on
// request and scans the buffer out in raster order on pixel ticks.
module vga_plot_sink
    import vga_plot_sink_pkg::*;
#(
    parameter int      WIDTH     = WIDTH_DEF,
    parameter int      HEIGHT    = HEIGHT_DEF,
    parameter int      H_BLANK   = 40,
    parameter int      V_BLANK   = 10,
    parameter colour_t BG_COLOUR = 3'd0
) (
    input  logic iClock,
    input  logic iResetn,
    vga_plot_sink_if.slave bus
);

    localparam int                DEPTH     = WIDTH * HEIGHT;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [7:0]        H_LAST    = 8'(WIDTH + H_BLANK - 1);
    localparam logic [7:0]        V_LAST    = 8'(HEIGHT + V_BLANK - 1);

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] clr_addr_reg;
    logic [7:0]        dropped_reg;
    logic [7:0]        hcount_reg, vcount_reg;
    logic [7:0]        raster_x_reg;
    logic [6:0]        raster_y_reg;
    logic              active_reg, hsync_reg, vsync_reg, frame_start_reg;

    logic              plot_in_range, plot_ok, plot_rej;
    logic              h_vis, v_vis, pix_active;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr, rd_addr;
    colour_t           wr_data, rd_data;

    assign plot_in_range = ({24'd0, bus.iX} < 32'(WIDTH)) && ({25'd0, bus.iY} < 32'(HEIGHT));
    assign plot_ok       = bus.iPlot && (state_reg == ST_IDLE) && plot_in_range;
    assign plot_rej      = bus.iPlot && !plot_ok;

    assign h_vis      = ({24'd0, hcount_reg} < 32'(WIDTH));
    assign v_vis      = ({24'd0, vcount_reg} < 32'(HEIGHT));
    assign pix_active = h_vis && v_vis;
    // Blank positions would map past the end of the buffer, so park the read.
    assign rd_addr    = pix_active ? xy_to_addr(hcount_reg, vcount_reg, WIDTH) : '0;

    // Clear FSM state register.
    always_ff @(posedge iClock or negedge iResetn) begin
        if (!iResetn) state_reg <= ST_IDLE;
        else          state_reg <= state_next;
    end

    // Clear FSM next state: a clear runs to completion and cannot be restarted.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (bus.iClear) state_next = ST_CLEAR;
            ST_CLEAR: if (clr_addr_reg == LAST_ADDR) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Clear address: held at 0 while idle so every clear starts at the top.
    always_ff @(posedge iClock or negedge iResetn) begin
        if (!iResetn)                  clr_addr_reg <= '0;
        else if (state_reg == ST_CLEAR) clr_addr_reg <= clr_addr_reg + 1'b1;
        else                           clr_addr_reg <= '0;
    end

    // Shared write port: the clear owns it while running, plots otherwise.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = BG_COLOUR;
        if (state_reg == ST_CLEAR) begin
            wr_en   = 1'b1;
            wr_addr = clr_addr_reg;
        end else if (plot_ok) begin
            wr_en   = 1'b1;
            wr_addr = xy_to_addr(bus.iX, {1'b0, bus.iY}, WIDTH);
            wr_data = bus.iColour;
        end
    end

    // Saturating count of rejected plots.
    always_ff @(posedge iClock or negedge iResetn) begin
        if (!iResetn)                             dropped_reg <= '0;
        else if (plot_rej && dropped_reg != 8'hFF) dropped_reg <= dropped_reg + 8'd1;
    end

    // Raster counters and output registers, stepped on pixel ticks only.
    always_ff @(posedge iClock or negedge iResetn) begin
        if (!iResetn) begin
            hcount_reg      <= '0;
            vcount_reg      <= '0;
            raster_x_reg    <= '0;
            raster_y_reg    <= '0;
            active_reg      <= 1'b0;
            hsync_reg       <= 1'b1;
            vsync_reg       <= 1'b1;
            frame_start_reg <= 1'b0;
        end else if (bus.iPixEn) begin
            raster_x_reg    <= hcount_reg;
            raster_y_reg    <= vcount_reg[6:0];
            active_reg      <= pix_active;
            hsync_reg       <= h_vis;
            vsync_reg       <= v_vis;
            frame_start_reg <= (hcount_reg == 8'd0) && (vcount_reg == 8'd0);
            if (hcount_reg == H_LAST) begin
                hcount_reg <= '0;
                vcount_reg <= (vcount_reg == V_LAST) ? 8'd0 : vcount_reg + 8'd1;
            end else begin
                hcount_reg <= hcount_reg + 8'd1;
            end
        end else begin
            frame_start_reg <= 1'b0;
        end
    end

    vga_plot_sink_fb_ram #(
        .DEPTH(DEPTH)
    ) u_fb_ram (
        .clk    (iClock),
        .we     (wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .re     (bus.iPixEn),
        .rd_addr(rd_addr),
        .rd_data(rd_data)
    );

    assign bus.oBusy       = (state_reg == ST_CLEAR);
    assign bus.oDropped    = dropped_reg;
    assign bus.oRasterX    = raster_x_reg;
    assign bus.oRasterY    = raster_y_reg;
    assign bus.oPixColour  = active_reg ? rd_data : 3'd0;
    assign bus.oActive     = active_reg;
    assign bus.oHSync      = hsync_reg;
    assign bus.oVSync      = vsync_reg;
    assign bus.oFrameStart = frame_start_reg;

endmodule

// File: tb/tb_vga_plot_sink.sv
// Bench for vga_plot_sink: table of plot vectors, hand sequences for clear,
// reset-mid-clear and the (0,0) collision, plus randomized traffic checked
// every cycle against a frame-level reference model.
module tb_vga_plot_sink;

    localparam int W     = 160;
    localparam int H     = 120;
    localparam int H_TOT = 200;
    localparam int V_TOT = 130;
    localparam int FRAME = H_TOT * V_TOT;
    localparam int NPIX  = W * H;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    vga_plot_sink_if bus ();

    vga_plot_sink dut (
        .iClock (clk),
        .iResetn(rstn),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: raster position as a linear index into the frame,
    // picture contents as a plain array, clear as a countdown of cycles.
    int fb_m [NPIX];
    int pos, last_pos, busy_left, dropped_m;
    int e_x, e_y, e_col, e_act, e_hs, e_vs, e_fs;

    typedef struct {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] col;
        logic       plot;
        int         exp_drop;
    } vec_t;
    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        pos = 0; last_pos = -1; busy_left = 0; dropped_m = 0;
        e_x = 0; e_y = 0; e_col = 0; e_act = 0; e_hs = 1; e_vs = 1; e_fs = 0;
    endtask

    // One clock with the inputs already on the bus; model updated from the
    // pre-edge state, outputs compared on the following falling edge.
    task automatic step();
        int h, v, x, y;
        bit idle;
        @(posedge clk);
        idle = (busy_left == 0);
        x = int'(bus.iX);
        y = int'(bus.iY);
        if (bus.iPixEn) begin
            h = pos % H_TOT;
            v = pos / H_TOT;
            e_act = (h < W && v < H) ? 1 : 0;
            e_x   = h;
            e_y   = v % 128;
            e_col = e_act ? fb_m[v * W + h] : 0;
            e_hs  = (h < W) ? 1 : 0;
            e_vs  = (v < H) ? 1 : 0;
            e_fs  = (pos == 0) ? 1 : 0;
            last_pos = pos;
            pos = (pos + 1) % FRAME;
        end else begin
            e_fs = 0;
        end
        if (bus.iPlot) begin
            if (idle && x < W && y < H) fb_m[y * W + x] = int'(bus.iColour);
            else if (dropped_m < 255) dropped_m++;
        end
        if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0) for (int i = 0; i < NPIX; i++) fb_m[i] = 0;
        end else if (bus.iClear) begin
            busy_left = NPIX;
        end
        @(negedge clk);
        check("busy",    bus.oBusy,       (busy_left > 0) ? 1 : 0);
        check("dropped", bus.oDropped,    dropped_m);
        check("rx",      bus.oRasterX,    e_x);
        check("ry",      bus.oRasterY,    e_y);
        check("pix",     bus.oPixColour,  e_col);
        check("active",  bus.oActive,     e_act);
        check("hsync",   bus.oHSync,      e_hs);
        check("vsync",   bus.oVSync,      e_vs);
        check("fstart",  bus.oFrameStart, e_fs);
    endtask

    // Asynchronous reset applied between edges; outputs must react at once.
    task automatic do_reset();
        bus.iPlot = 1'b0; bus.iClear = 1'b0; bus.iPixEn = 1'b0;
        rstn = 1'b0;
        #1;
        check("rst_busy",    bus.oBusy,       0);
        check("rst_dropped", bus.oDropped,    0);
        check("rst_hsync",   bus.oHSync,      1);
        check("rst_vsync",   bus.oVSync,      1);
        check("rst_active",  bus.oActive,     0);
        check("rst_pix",     bus.oPixColour,  0);
        check("rst_fstart",  bus.oFrameStart, 0);
        check("rst_rx",      bus.oRasterX,    0);
        check("rst_ry",      bus.oRasterY,    0);
        model_reset();
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    // Hand checks around the plotted pixel (5,3) while scanning.
    task automatic check_plot_area();
        if (last_pos == 3 * H_TOT + 5) begin
            check("p53_col", bus.oPixColour, 6);
            check("p53_act", bus.oActive, 1);
        end
        if (last_pos == 3 * H_TOT + 4 || last_pos == 3 * H_TOT + 6 ||
            last_pos == 2 * H_TOT + 5 || last_pos == 4 * H_TOT + 5)
            check("p53_nbr", bus.oPixColour, 0);
    endtask

    initial begin
        int busy_cnt, n_clr_plots, guard;
        rstn = 1'b0;
        bus.iX = '0; bus.iY = '0; bus.iColour = '0;
        bus.iPlot = 1'b0; bus.iClear = 1'b0; bus.iPixEn = 1'b0;
        for (int i = 0; i < NPIX; i++) fb_m[i] = 0;

        vecs[0] = '{8'd160, 7'd0,   3'd1, 1'b1, 1};
        vecs[1] = '{8'd0,   7'd120, 3'd2, 1'b1, 2};
        vecs[2] = '{8'd5,   7'd3,   3'd6, 1'b1, 2};
        vecs[3] = '{8'd159, 7'd119, 3'd5, 1'b1, 2};
        vecs[4] = '{8'd255, 7'd127, 3'd7, 1'b1, 3};
        vecs[5] = '{8'd10,  7'd10,  3'd3, 1'b0, 3};
        vecs[6] = '{8'd0,   7'd0,   3'd4, 1'b1, 3};
        vecs[7] = '{8'd200, 7'd5,   3'd1, 1'b1, 4};

        @(negedge clk);
        do_reset();

        // Plot acceptance table, raster idle.
        foreach (vecs[i]) begin
            bus.iX = vecs[i].x; bus.iY = vecs[i].y; bus.iColour = vecs[i].col;
            bus.iPlot = vecs[i].plot;
            step();
            check("tbl_dropped", bus.oDropped, vecs[i].exp_drop);
        end

        // Saturation of the reject counter.
        for (int i = 0; i < 300; i++) begin
            bus.iX = 8'($urandom_range(160, 255)); bus.iY = 7'($urandom_range(0, 127));
            bus.iPlot = 1'b1;
            step();
        end
        bus.iPlot = 1'b0;
        check("sat_dropped", bus.oDropped, 255);

        do_reset();

        // Clear aborted by reset at cycle 1000.
        bus.iClear = 1'b1; step(); bus.iClear = 1'b0;
        repeat (999) step();
        check("midclr_busy", bus.oBusy, 1);
        do_reset();

        // Full clear with rejected plots and an ignored re-request.
        busy_cnt = 0; n_clr_plots = 0;
        bus.iClear = 1'b1; step(); bus.iClear = 1'b0;
        check("clr_rise", bus.oBusy, 1);
        for (int c = 0; c < 20000 && bus.oBusy; c++) begin
            busy_cnt++;
            bus.iClear = (c == 3000);
            bus.iPlot  = (c % 1000 == 500);
            if (bus.iPlot) n_clr_plots++;
            bus.iX = 8'($urandom_range(0, 159)); bus.iY = 7'($urandom_range(0, 119));
            bus.iColour = 3'($urandom_range(1, 7));
            step();
        end
        bus.iPlot = 1'b0; bus.iClear = 1'b0;
        check("clr_len", busy_cnt, NPIX);
        check("clr_drops", bus.oDropped, n_clr_plots);

        // Random traffic, rows 10 and below only, keeping the top-left area clean.
        for (int i = 0; i < 2000; i++) begin
            bus.iPixEn  = 1'($urandom_range(0, 1));
            bus.iPlot   = ($urandom_range(0, 3) == 0);
            bus.iX      = 8'($urandom_range(1, 170));
            bus.iY      = 7'($urandom_range(10, 125));
            bus.iColour = 3'($urandom);
            step();
        end

        bus.iPlot = 1'b1; bus.iX = 8'd5; bus.iY = 7'd3; bus.iColour = 3'd6;
        bus.iPixEn = 1'b1;
        step();
        bus.iPlot = 1'b0;

        // Scan until the raster is about to present (0,0).
        guard = 0;
        while (pos != 0 && guard < FRAME + 2) begin
            step(); check_plot_area(); guard++;
        end
        check("reach_origin", pos, 0);

        // Write (0,0) on the very edge it is read: old value shows.
        bus.iPlot = 1'b1; bus.iX = 8'd0; bus.iY = 7'd0; bus.iColour = 3'd7;
        step();
        bus.iPlot = 1'b0;
        check("coll_fstart", bus.oFrameStart, 1);
        check("coll_pix", bus.oPixColour, 0);

        // One full frame, then (0,0) again carries the new colour.
        guard = 0;
        while (pos != 0 && guard < FRAME + 2) begin
            step(); check_plot_area(); guard++;
        end
        check("reach_origin2", pos, 0);
        step();
        check("next_fstart", bus.oFrameStart, 1);
        check("next_pix", bus.oPixColour, 7);
        check("next_rx", bus.oRasterX, 0);

        bus.iPixEn = 1'b0;
        step();
        check("hold_fs_clear", bus.oFrameStart, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
